dma_sequencer: RTL and testbench
================================

// Module: dma_sequencer
// PURPOSE
//  Control sequencer that sits directly upstream of the AM2940 DMA address generator and drives its instruction port.
//  On start it programs the control register, address and word count.
//  It then runs one memory transfer per beat: req/ack handshake, then an AM2940 counter step.
//  It stops when the AM2940 Done output asserts, on abort, or on ack timeout.
// PARAMETERS
//  DATA_W   8   width of AM2940 data/address bus and configuration words
//  CTRL_W   3   width of AM2940 control word (mode bits)
//  TMO_W    4   width of ack timeout counter; timeout = 2**TMO_W-1 cycles waiting for mem_ack
// PORTS
//  clk        in   1       system clock, all state changes on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       one-cycle request to begin a transfer; ignored while busy
//  abort      in   1       terminate current transfer; highest priority after reset
//  cfg_mode   in   CTRL_W  AM2940 control word, captured on accepted start
//  cfg_addr   in   DATA_W  start address, captured on accepted start
//  cfg_count  in   DATA_W  word count, captured on accepted start
//  am_instr   out  3       AM2940 Instruction
//  am_data    out  DATA_W  AM2940 DataInput
//  am_aci     out  1       AM2940 ACI, active-low count enable
//  am_wci     out  1       AM2940 WCI, active-low count enable
//  am_done    in   1       AM2940 Done
//  mem_req    out  1       memory transfer request for address AddressOut
//  mem_ack    in   1       memory accepted beat
//  busy       out  1       high from accepted start until return to IDLE
//  done_pulse out  1       one-cycle pulse on normal completion
//  err        out  1       sticky timeout flag, cleared by next accepted start
// BEHAVIOUR
//  AM2940 encoding: 000 WR_CTRL, 001 RD_CTRL, 010 RD_WC, 011 RD_AC, 100 REINIT, 101 LD_ADDR, 110 LD_WC, 111 ENABLE.
//  Reset (async, rst_n=0): state=IDLE, am_instr=011, am_data=0, am_aci=am_wci=1, mem_req=0, busy=0, done_pulse=0, err=0.
//  All outputs are registered.
//  State machine, one state per cycle unless noted:
//   IDLE   : am_instr=011, aci=wci=1. On start, capture cfg_*, clear err, set busy -> WCTRL.
//   WCTRL  : am_instr=000, am_data={0,mode} -> LADDR.
//   LADDR  : am_instr=101, am_data=addr -> LWC.
//   LWC    : am_instr=110, am_data=count -> REQ.
//   REQ    : am_instr=111, aci=wci=1, mem_req=1. Hold until mem_ack -> STEP.
//            Timeout counter increments each waiting cycle; on reaching all-ones, set err -> IDLE.
//   STEP   : mem_req=0, am_instr=111, aci=wci=0 for exactly one cycle, so the counters advance once -> CHECK.
//   CHECK  : am_instr=111, aci=wci=1. Sample am_done, which reflects the post-step counters.
//            If 1: done_pulse=1 -> IDLE. Otherwise -> REQ.
//  Exactly one AM2940 count step per acknowledged beat; mem_ack outside REQ is ignored.
//  Timeout counter clears on entry to REQ.
//  abort in any non-IDLE state: next cycle IDLE. mem_req drops, aci=wci=1, no done_pulse, err unchanged.
//  start and abort in the same cycle while IDLE: start wins, abort is ignored.
//  start while busy: ignored, and captured config is unchanged.
//  Count wrap and the zero-count case are resolved solely by am_done; there is no special case for cfg_count=0.
//  Reset mid-transfer: immediate return to reset values; mem_req falls asynchronously.
//  busy falls in the same cycle that done_pulse is high (IDLE entry).
// STRUCTURE
//  Shared package am2940_pkg: instruction localparams (AM_WR_CTRL..AM_ENABLE), state encoding, default DATA_W/CTRL_W.
//  Single module with no sub-modules. Timeout counter is inline; FSM is one registered next-state process.
// TESTING (bench instantiates dma_sequencer + AM2940 + memory ack model)
//  1. Reset, then start with mode=3, addr=0x88, count=0x03, ack after 1 cycle:
//     - instr sequence 000,101,110,111
//     - AddressOut steps 0x88->0x89->0x8A...
//     - done_pulse after am_done; busy low the same cycle.
//  2. Ack delayed 5 cycles each beat: mem_req held stable; exactly one aci/wci low cycle per ack; address advances by 1 per ack.
//  3. mem_ack never asserted: err=1 after 15 REQ cycles, IDLE, mem_req=0, no done_pulse; next start clears err.
//  4. abort in 2nd REQ: IDLE next cycle, no done_pulse, AddressOut frozen at 0x89.
//  5. start pulses during busy with different cfg: ignored; completion matches original config.
//  6. rst_n low in STEP: all outputs at reset values immediately; new start then runs cleanly from WCTRL.

Source files
------------

// File: rtl/am2940_pkg.sv
// Shared definitions for blocks that drive the AM2940 DMA address generator:
// instruction codes, sequencer state encoding and default bus widths.
package am2940_pkg;

    localparam int AM2940_DATA_W = 8;
    localparam int AM2940_CTRL_W = 3;
    localparam int AM2940_TMO_W  = 4;

    localparam logic [2:0] AM_WR_CTRL = 3'b000;
    localparam logic [2:0] AM_RD_CTRL = 3'b001;
    localparam logic [2:0] AM_RD_WC   = 3'b010;
    localparam logic [2:0] AM_RD_AC   = 3'b011;
    localparam logic [2:0] AM_REINIT  = 3'b100;
    localparam logic [2:0] AM_LD_ADDR = 3'b101;
    localparam logic [2:0] AM_LD_WC   = 3'b110;
    localparam logic [2:0] AM_ENABLE  = 3'b111;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WCTRL,
        SEQ_LADDR,
        SEQ_LWC,
        SEQ_REQ,
        SEQ_STEP,
        SEQ_CHECK
    } seq_state_t;

endpackage

// File: rtl/dma_sequencer.sv
// Control sequencer sitting in front of an AM2940. It programs the control
// word, start address and word count, then runs one req/ack memory beat
// followed by exactly one AM2940 count step per beat until Done, abort or
// an ack timeout. Every output comes straight from a flop.
module dma_sequencer
    import am2940_pkg::*;
#(
    parameter int DATA_W = AM2940_DATA_W,
    parameter int CTRL_W = AM2940_CTRL_W,
    parameter int TMO_W  = AM2940_TMO_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CTRL_W-1:0] cfg_mode,
    input  logic [DATA_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_count,
    output logic [2:0]        am_instr,
    output logic [DATA_W-1:0] am_data,
    output logic              am_aci,
    output logic              am_wci,
    input  logic              am_done,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done_pulse,
    output logic              err
);

    localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    seq_state_t        state_q, state_d;
    logic [CTRL_W-1:0] mode_q, mode_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [TMO_W-1:0]  tmoInc;
    logic              err_q, err_d;
    logic              done_pulse_q, done_pulse_d;
    logic [2:0]        am_instr_q, am_instr_d;
    logic [DATA_W-1:0] am_data_q, am_data_d;
    logic              am_aci_q, am_aci_d;
    logic              am_wci_q, am_wci_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;

    assign tmoInc = tmo_q + TMO_ONE;

    // Next-state, captured config, timeout counter and the output values
    // that belong to the state being entered (so outputs can be registered).
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        count_d      = count_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        done_pulse_d = 1'b0;
        am_instr_d   = AM_RD_AC;
        am_data_d    = '0;
        am_aci_d     = 1'b1;
        am_wci_d     = 1'b1;
        mem_req_d    = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    mode_d  = cfg_mode;
                    addr_d  = cfg_addr;
                    count_d = cfg_count;
                    err_d   = 1'b0;
                    state_d = SEQ_WCTRL;
                end
            end
            SEQ_WCTRL: state_d = SEQ_LADDR;
            SEQ_LADDR: state_d = SEQ_LWC;
            SEQ_LWC: begin
                tmo_d   = '0;
                state_d = SEQ_REQ;
            end
            SEQ_REQ: begin
                if (mem_ack) begin
                    state_d = SEQ_STEP;
                end else if (&tmoInc) begin
                    tmo_d   = tmoInc;
                    err_d   = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    tmo_d = tmoInc;
                end
            end
            SEQ_STEP: state_d = SEQ_CHECK;
            SEQ_CHECK: begin
                if (am_done) begin
                    done_pulse_d = 1'b1;
                    state_d      = SEQ_IDLE;
                end else begin
                    tmo_d   = '0;
                    state_d = SEQ_REQ;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        // Abort overrides everything except a start that is seen in IDLE.
        if (abort && (state_q != SEQ_IDLE)) begin
            state_d      = SEQ_IDLE;
            done_pulse_d = 1'b0;
            err_d        = err_q;
            tmo_d        = tmo_q;
        end

        case (state_d)
            SEQ_WCTRL: begin
                am_instr_d = AM_WR_CTRL;
                am_data_d  = {{(DATA_W-CTRL_W){1'b0}}, mode_d};
            end
            SEQ_LADDR: begin
                am_instr_d = AM_LD_ADDR;
                am_data_d  = addr_d;
            end
            SEQ_LWC: begin
                am_instr_d = AM_LD_WC;
                am_data_d  = count_d;
            end
            SEQ_REQ: begin
                am_instr_d = AM_ENABLE;
                mem_req_d  = 1'b1;
            end
            SEQ_STEP: begin
                am_instr_d = AM_ENABLE;
                am_aci_d   = 1'b0;
                am_wci_d   = 1'b0;
            end
            SEQ_CHECK: am_instr_d = AM_ENABLE;
            default:   am_instr_d = AM_RD_AC;
        endcase

        busy_d = (state_d != SEQ_IDLE);
    end

    // State, config and output registers; reset forces the idle values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEQ_IDLE;
            mode_q       <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            am_instr_q   <= AM_RD_AC;
            am_data_q    <= '0;
            am_aci_q     <= 1'b1;
            am_wci_q     <= 1'b1;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            done_pulse_q <= done_pulse_d;
            am_instr_q   <= am_instr_d;
            am_data_q    <= am_data_d;
            am_aci_q     <= am_aci_d;
            am_wci_q     <= am_wci_d;
            mem_req_q    <= mem_req_d;
            busy_q       <= busy_d;
        end
    end

    assign am_instr   = am_instr_q;
    assign am_data    = am_data_q;
    assign am_aci     = am_aci_q;
    assign am_wci     = am_wci_q;
    assign mem_req    = mem_req_q;
    assign busy       = busy_q;
    assign done_pulse = done_pulse_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Bench for dma_sequencer with a small AM2940 behavioural model and a
// memory ack model with programmable delay.
module tb_dma_sequencer;
    import am2940_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] cfg_mode;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_count;
    logic [2:0] am_instr;
    logic [7:0] am_data;
    logic       am_aci;
    logic       am_wci;
    logic       am_done;
    logic       mem_req;
    logic       mem_ack;
    logic       busy;
    logic       done_pulse;
    logic       err;

    int checks = 0;
    int errors = 0;

    // AM2940 model: control register, address counter, word counter.
    logic [2:0] amCtrl = 3'b000;
    logic [7:0] amAc   = 8'h00;
    logic [7:0] amWc   = 8'hFF;

    // Memory ack model state.
    int   ackDelay  = 1;
    logic ackEnable = 1'b1;
    int   waitCnt   = 0;

    dma_sequencer #(.DATA_W(8), .CTRL_W(3), .TMO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
        .am_instr(am_instr), .am_data(am_data), .am_aci(am_aci), .am_wci(am_wci),
        .am_done(am_done), .mem_req(mem_req), .mem_ack(mem_ack),
        .busy(busy), .done_pulse(done_pulse), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AM2940 executes the instruction present at each rising edge.
    always @(posedge clk) begin
        case (am_instr)
            AM_WR_CTRL: amCtrl <= am_data[2:0];
            AM_LD_ADDR: amAc   <= am_data;
            AM_LD_WC:   amWc   <= am_data;
            AM_ENABLE: begin
                if (!am_aci) amAc <= amCtrl[2] ? amAc - 8'd1 : amAc + 8'd1;
                if (!am_wci) amWc <= amWc - 8'd1;
            end
            default: ;
        endcase
    end
    assign am_done = (amWc == 8'h00);

    // Memory answers after mem_req has been high for ackDelay cycles.
    always @(negedge clk) begin
        if (mem_req) begin
            waitCnt <= waitCnt + 1;
            mem_ack <= ackEnable && ((waitCnt + 1) >= ackDelay);
        end else begin
            waitCnt <= 0;
            mem_ack <= 1'b0;
        end
    end

    typedef struct {
        logic       start;
        logic [2:0] expInstr;
        logic [7:0] expData;
        logic       expReq;
        logic       expCnt;
        logic       expBusy;
        logic       expDone;
        logic [7:0] expAddr;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mkVec(logic s, logic [2:0] i, logic [7:0] d, logic r,
                                   logic c, logic b, logic dn, logic [7:0] a);
        vec_t v;
        v.start = s; v.expInstr = i; v.expData = d; v.expReq = r;
        v.expCnt = c; v.expBusy = b; v.expDone = dn; v.expAddr = a;
        return v;
    endfunction

    task automatic applyStimulus(input logic s, input logic a, input logic [2:0] m,
                                 input logic [7:0] ad, input logic [7:0] c);
        start     = s;
        abort     = a;
        cfg_mode  = m;
        cfg_addr  = ad;
        cfg_count = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues a start, then observes the run until busy falls (bounded).
    task automatic runTransfer(input string name, input logic [2:0] m, input logic [7:0] ad,
                               input logic [7:0] c, input int expRun, input logic decoy,
                               output int beats, output int lowCycles, output int badRun,
                               output int reqTotal, output logic doneSeen,
                               output logic busyAtDone, output logic firstErr,
                               output logic [2:0] firstInstr);
        logic ended;
        logic first;
        int   runLen;
        ended = 0; first = 1; runLen = 0;
        beats = 0; lowCycles = 0; badRun = 0; reqTotal = 0;
        doneSeen = 0; busyAtDone = 1; firstErr = 1'bx; firstInstr = 3'bxxx;
        applyStimulus(1, 0, m, ad, c);
        for (int cyc = 0; cyc < 400 && !ended; cyc++) begin
            @(negedge clk);
            if (first) begin
                firstErr   = err;
                firstInstr = am_instr;
                first      = 0;
            end
            if (mem_req) begin
                reqTotal++;
                runLen++;
            end else if (runLen != 0) begin
                beats++;
                if (runLen != expRun) badRun++;
                runLen = 0;
            end
            if (!am_aci || !am_wci) lowCycles++;
            if (done_pulse) begin
                doneSeen   = 1;
                busyAtDone = busy;
            end
            if (!busy) ended = 1;
            if (decoy && busy) applyStimulus(1, 0, 3'd4, 8'h00, 8'h07);
            else               applyStimulus(0, 0, m, ad, c);
        end
        checkOutput({name, "_ended"}, {31'd0, ended}, 32'd1);
    endtask

    int         beats, lowCycles, badRun, reqTotal;
    logic       doneSeen, busyAtDone, firstErr;
    logic [2:0] firstInstr;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        logic prevReq;
        logic sawDone;
        int   reqRises;

        rst_n = 1'b0;
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {16'd0, am_instr, am_data, am_aci, am_wci, mem_req, busy, done_pulse, err},
                    {16'd0, 3'b011, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transfer: mode 3, addr 0x88, count 3, ack after 1 cycle.
        $display("[TB] basic transfer table");
        vecs[0]  = mkVec(1, 3'b011, 8'h00, 0, 1, 0, 0, 8'h00);
        vecs[1]  = mkVec(0, 3'b000, 8'h03, 0, 1, 1, 0, 8'h00);
        vecs[2]  = mkVec(0, 3'b101, 8'h88, 0, 1, 1, 0, 8'h00);
        vecs[3]  = mkVec(0, 3'b110, 8'h03, 0, 1, 1, 0, 8'h88);
        vecs[4]  = mkVec(0, 3'b111, 8'h00, 1, 1, 1, 0, 8'h88);
        vecs[5]  = mkVec(0, 3'b111, 8'h00, 0, 0, 1, 0, 8'h88);
        vecs[6]  = mkVec(0, 3'b111, 8'h00, 0, 1, 1, 0, 8'h89);
        vecs[7]  = mkVec(0, 3'b111, 8'h00, 1, 1, 1, 0, 8'h89);
        vecs[8]  = mkVec(0, 3'b111, 8'h00, 0, 0, 1, 0, 8'h89);
        vecs[9]  = mkVec(0, 3'b111, 8'h00, 0, 1, 1, 0, 8'h8A);
        vecs[10] = mkVec(0, 3'b111, 8'h00, 1, 1, 1, 0, 8'h8A);
        vecs[11] = mkVec(0, 3'b111, 8'h00, 0, 0, 1, 0, 8'h8A);
        vecs[12] = mkVec(0, 3'b111, 8'h00, 0, 1, 1, 0, 8'h8B);
        vecs[13] = mkVec(0, 3'b011, 8'h00, 0, 1, 0, 1, 8'h8B);
        vecs[14] = mkVec(0, 3'b011, 8'h00, 0, 1, 0, 0, 8'h8B);
        ackDelay = 1;
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("basic_row%0d", i),
                        {8'd0, am_instr, am_data, mem_req, am_aci, am_wci, busy, done_pulse, amAc},
                        {8'd0, vecs[i].expInstr, vecs[i].expData, vecs[i].expReq, vecs[i].expCnt,
                         vecs[i].expCnt, vecs[i].expBusy, vecs[i].expDone, vecs[i].expAddr});
            applyStimulus(vecs[i].start, 0, 3'd3, 8'h88, 8'h03);
            @(negedge clk);
        end

        // Slow memory: ack after 5 cycles per beat.
        $display("[TB] delayed ack");
        ackDelay = 5;
        runTransfer("slow", 3'd3, 8'h10, 8'h02, 5, 0, beats, lowCycles, badRun, reqTotal,
                    doneSeen, busyAtDone, firstErr, firstInstr);
        checkOutput("slow_beats", beats, 2);
        checkOutput("slow_req_stable", badRun, 0);
        checkOutput("slow_steps", lowCycles, 2);
        checkOutput("slow_done", {31'd0, doneSeen}, 1);
        checkOutput("slow_busy_at_done", {31'd0, busyAtDone}, 0);
        checkOutput("slow_addr", {24'd0, amAc}, 32'h12);

        // No ack at all: timeout after 15 REQ cycles.
        $display("[TB] ack timeout");
        ackEnable = 1'b0;
        runTransfer("tmo", 3'd3, 8'h30, 8'h04, 15, 0, beats, lowCycles, badRun, reqTotal,
                    doneSeen, busyAtDone, firstErr, firstInstr);
        checkOutput("tmo_req_cycles", reqTotal, 15);
        checkOutput("tmo_no_step", lowCycles, 0);
        checkOutput("tmo_no_done", {31'd0, doneSeen}, 0);
        checkOutput("tmo_end_state", {28'd0, err, mem_req, busy, done_pulse}, {28'd0, 4'b1000});
        @(negedge clk);
        checkOutput("tmo_err_sticky", {31'd0, err}, 1);
        ackEnable = 1'b1;
        ackDelay  = 1;
        runTransfer("retry", 3'd3, 8'h20, 8'h01, 1, 0, beats, lowCycles, badRun, reqTotal,
                    doneSeen, busyAtDone, firstErr, firstInstr);
        checkOutput("retry_err_cleared", {31'd0, firstErr}, 0);
        checkOutput("retry_first_instr", {29'd0, firstInstr}, {29'd0, AM_WR_CTRL});
        checkOutput("retry_done", {31'd0, doneSeen}, 1);
        checkOutput("retry_addr", {24'd0, amAc}, 32'h21);

        // Start together with abort in IDLE, then abort in the 2nd REQ.
        $display("[TB] abort");
        ackDelay = 3;
        applyStimulus(1, 1, 3'd3, 8'h88, 8'h03);
        @(negedge clk);
        checkOutput("start_beats_abort", {28'd0, busy, am_instr}, {28'd0, 1'b1, AM_WR_CTRL});
        applyStimulus(0, 0, 3'd3, 8'h88, 8'h03);
        found = 0; prevReq = 0; reqRises = 0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            @(negedge clk);
            if (mem_req && !prevReq) reqRises++;
            prevReq = mem_req;
            if (reqRises == 2) begin
                abort = 1'b1;
                found = 1;
            end
        end
        checkOutput("abort_reached_req2", {31'd0, found}, 1);
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle",
                    {20'd0, am_instr, am_aci, am_wci, mem_req, busy, done_pulse, err, amAc},
                    {20'd0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h89});
        sawDone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_pulse || busy) sawDone = 1;
        end
        checkOutput("abort_stays_idle", {31'd0, sawDone}, 0);
        checkOutput("abort_addr_frozen", {24'd0, amAc}, 32'h89);

        // Start pulses while busy with a different config are ignored.
        $display("[TB] start while busy");
        ackDelay = 1;
        runTransfer("busy_start", 3'd3, 8'h40, 8'h02, 1, 1, beats, lowCycles, badRun, reqTotal,
                    doneSeen, busyAtDone, firstErr, firstInstr);
        checkOutput("busy_start_beats", beats, 2);
        checkOutput("busy_start_done", {31'd0, doneSeen}, 1);
        checkOutput("busy_start_addr", {24'd0, amAc}, 32'h42);
        checkOutput("busy_start_ctrl", {29'd0, amCtrl}, 32'd3);
        @(negedge clk);
        checkOutput("busy_start_idle_after", {31'd0, busy}, 0);

        // Reset during STEP, then a clean transfer.
        $display("[TB] reset mid-transfer");
        ackDelay = 2;
        applyStimulus(1, 0, 3'd3, 8'h50, 8'h03);
        @(negedge clk);
        applyStimulus(0, 0, 3'd3, 8'h50, 8'h03);
        found = 0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            @(negedge clk);
            if (!am_aci) found = 1;
        end
        checkOutput("rst_reached_step", {31'd0, found}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_outputs",
                    {16'd0, am_instr, am_data, am_aci, am_wci, mem_req, busy, done_pulse, err},
                    {16'd0, 3'b011, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        checkOutput("rst_no_step", {24'd0, amAc}, 32'h50);
        rst_n = 1'b1;
        @(negedge clk);
        runTransfer("after_rst", 3'd3, 8'h60, 8'h02, 2, 0, beats, lowCycles, badRun, reqTotal,
                    doneSeen, busyAtDone, firstErr, firstInstr);
        checkOutput("after_rst_first_instr", {29'd0, firstInstr}, {29'd0, AM_WR_CTRL});
        checkOutput("after_rst_beats", beats, 2);
        checkOutput("after_rst_done", {31'd0, doneSeen}, 1);
        checkOutput("after_rst_addr", {24'd0, amAc}, 32'h62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
